// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU data-memory path.
// Holds the per-channel arbiter state encoding and a small helper for index widths.
package gpu_pkg;

  // Channel FSM encoding, kept as plain constants for compatibility with older consumers.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ArbIdle      = 2'd0;
  localparam arb_state_t ArbReadWait  = 2'd1;
  localparam arb_state_t ArbWriteWait = 2'd2;
  localparam arb_state_t ArbRelay     = 2'd3;

  // Width of an index into n items; never zero so single-item configs still elaborate.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_channel.sv
// One memory-side channel of the data memory arbiter.
// Holds the claimed consumer, the latched request and the channel FSM.
// Ports:
//   clk, reset                       clock, async active-low reset
//   grant_*                          claim decision from the top (valid only in ArbIdle)
//   relay_valid                      claimed consumer's valid for the active direction
//   mem_read_ready, mem_write_ready  memory completion strobes
//   state, sel, is_read, rr_ptr      channel status used for claim resolution
//   mem_*                            registered memory request outputs
//   read_done, write_done            completion this cycle (drives consumer ready next edge)
module arb_channel
  import gpu_pkg::*;
#(
  parameter int unsigned NumConsumers = 4,
  parameter int unsigned AddrBits     = 12,
  parameter int unsigned DataBits     = 16,
  parameter int unsigned IdxW         = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                grant_valid,
  input  logic [IdxW-1:0]     grant_idx,
  input  logic                grant_is_read,
  input  logic [AddrBits-1:0] grant_addr,
  input  logic [DataBits-1:0] grant_data,
  input  logic                relay_valid,
  input  logic                mem_read_ready,
  input  logic                mem_write_ready,
  output arb_state_t          state,
  output logic [IdxW-1:0]     sel,
  output logic                is_read,
  output logic [IdxW-1:0]     rr_ptr,
  output logic                mem_read_valid,
  output logic [AddrBits-1:0] mem_read_address,
  output logic                mem_write_valid,
  output logic [AddrBits-1:0] mem_write_address,
  output logic [DataBits-1:0] mem_write_data,
  output logic                read_done,
  output logic                write_done
);

  arb_state_t          state_q, state_d;
  logic [IdxW-1:0]     sel_q, sel_d;
  logic                is_read_q, is_read_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [AddrBits-1:0] rd_addr_q, rd_addr_d;
  logic                wr_valid_q, wr_valid_d;
  logic [AddrBits-1:0] wr_addr_q, wr_addr_d;
  logic [DataBits-1:0] wr_data_q, wr_data_d;
  logic [IdxW-1:0]     next_ptr;

  assign read_done  = (state_q == ArbReadWait) && mem_read_ready;
  assign write_done = (state_q == ArbWriteWait) && mem_write_ready;

  always_comb begin
    if (32'(grant_idx) == NumConsumers - 1) next_ptr = '0;
    else                                    next_ptr = grant_idx + IdxW'(1);
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    is_read_d  = is_read_q;
    rr_ptr_d   = rr_ptr_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      ArbIdle: begin
        if (grant_valid) begin
          sel_d     = grant_idx;
          is_read_d = grant_is_read;
          rr_ptr_d  = next_ptr;
          if (grant_is_read) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = grant_addr;
            state_d    = ArbReadWait;
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = grant_addr;
            wr_data_d  = grant_data;
            state_d    = ArbWriteWait;
          end
        end
      end
      ArbReadWait: begin
        if (mem_read_ready) begin
          rd_valid_d = 1'b0;
          state_d    = ArbRelay;
        end
      end
      ArbWriteWait: begin
        if (mem_write_ready) begin
          wr_valid_d = 1'b0;
          state_d    = ArbRelay;
        end
      end
      ArbRelay: begin
        // Hold the claim until the consumer has seen ready and dropped its request.
        if (!relay_valid) state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ArbIdle;
      sel_q      <= '0;
      is_read_q  <= 1'b0;
      rr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      is_read_q  <= is_read_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign state             = state_q;
  assign sel               = sel_q;
  assign is_read           = is_read_q;
  assign rr_ptr            = rr_ptr_q;
  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares NUM_CHANNELS memory channels among NUM_CONSUMERS LSU ports.
// Ports:
//   clk, reset            clock, async active-low reset
//   consumer_read_*       per-consumer read request/ready/data
//   consumer_write_*      per-consumer write request/ready
//   mem_read_*            per-channel memory read interface
//   mem_write_*           per-channel memory write interface
// Claim resolution lives here; each channel's FSM lives in arb_channel.
module data_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 2,
  parameter int unsigned ADDR_BITS     = 12,
  parameter int unsigned DATA_BITS     = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int unsigned CIdxW = idx_width(NUM_CONSUMERS);

  arb_state_t       ch_state       [NUM_CHANNELS];
  logic [CIdxW-1:0] ch_sel         [NUM_CHANNELS];
  logic [CIdxW-1:0] ch_rr_ptr      [NUM_CHANNELS];
  logic             ch_is_read     [NUM_CHANNELS];
  logic             ch_relay_valid [NUM_CHANNELS];
  logic             ch_read_done   [NUM_CHANNELS];
  logic             ch_write_done  [NUM_CHANNELS];
  logic             grant_valid    [NUM_CHANNELS];
  logic [CIdxW-1:0] grant_idx      [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0] consumer_req;
  logic [NUM_CONSUMERS-1:0] claimed;
  logic [NUM_CONSUMERS-1:0] taken;
  int unsigned              scan;
  logic [CIdxW-1:0]         scan_idx;

  assign consumer_req = consumer_read_valid | consumer_write_valid;

  // Channels resolve in index order; each pick is marked taken before the next channel looks,
  // so no consumer can be granted twice in one cycle.
  always_comb begin
    claimed = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (ch_state[ch] != ArbIdle) claimed[ch_sel[ch]] = 1'b1;
    end
    taken    = claimed;
    scan     = 0;
    scan_idx = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_valid[ch] = 1'b0;
      grant_idx[ch]   = '0;
      if (ch_state[ch] == ArbIdle) begin
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
          scan = 32'(ch_rr_ptr[ch]) + k;
          if (scan >= NUM_CONSUMERS) scan = scan - NUM_CONSUMERS;
          scan_idx = CIdxW'(scan);
          if (!grant_valid[ch] && consumer_req[scan_idx] && !taken[scan_idx]) begin
            grant_valid[ch] = 1'b1;
            grant_idx[ch]   = scan_idx;
          end
        end
        if (grant_valid[ch]) taken[grant_idx[ch]] = 1'b1;
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    logic                 grant_is_read;
    logic [ADDR_BITS-1:0] grant_addr;

    // Read wins when a consumer has both requests up.
    assign grant_is_read = consumer_read_valid[grant_idx[ch]];
    assign grant_addr    = grant_is_read ? consumer_read_address[grant_idx[ch]]
                                         : consumer_write_address[grant_idx[ch]];
    assign ch_relay_valid[ch] = ch_is_read[ch] ? consumer_read_valid[ch_sel[ch]]
                                               : consumer_write_valid[ch_sel[ch]];

    arb_channel #(
      .NumConsumers(NUM_CONSUMERS),
      .AddrBits    (ADDR_BITS),
      .DataBits    (DATA_BITS),
      .IdxW        (CIdxW)
    ) u_channel (
      .clk              (clk),
      .reset            (reset),
      .grant_valid      (grant_valid[ch]),
      .grant_idx        (grant_idx[ch]),
      .grant_is_read    (grant_is_read),
      .grant_addr       (grant_addr),
      .grant_data       (consumer_write_data[grant_idx[ch]]),
      .relay_valid      (ch_relay_valid[ch]),
      .mem_read_ready   (mem_read_ready[ch]),
      .mem_write_ready  (mem_write_ready[ch]),
      .state            (ch_state[ch]),
      .sel              (ch_sel[ch]),
      .is_read          (ch_is_read[ch]),
      .rr_ptr           (ch_rr_ptr[ch]),
      .mem_read_valid   (mem_read_valid[ch]),
      .mem_read_address (mem_read_address[ch]),
      .mem_write_valid  (mem_write_valid[ch]),
      .mem_write_address(mem_write_address[ch]),
      .mem_write_data   (mem_write_data[ch]),
      .read_done        (ch_read_done[ch]),
      .write_done       (ch_write_done[ch])
    );
  end

  logic [NUM_CONSUMERS-1:0]                rd_ready_d, rd_ready_q;
  logic [NUM_CONSUMERS-1:0]                wr_ready_d, wr_ready_q;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_d, rd_data_q;

  // Read data is held per consumer until its next read completes.
  always_comb begin
    rd_ready_d = '0;
    wr_ready_d = '0;
    rd_data_d  = rd_data_q;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (ch_read_done[ch]) begin
        rd_ready_d[ch_sel[ch]] = 1'b1;
        rd_data_d[ch_sel[ch]]  = mem_read_data[ch];
      end
      if (ch_write_done[ch]) wr_ready_d[ch_sel[ch]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign consumer_read_data   = rd_data_q;

endmodule
